dispatch_queue_ctrl: RTL and testbench
======================================

Name: dispatch_queue_ctrl

Overview:
- In-order buffering and issue controller between the decode stage and the reservation stations (RS) / reorder buffer (ROB) of the out-of-order core.
- Accepts one decoded instruction per cycle into a circular queue.
- Releases the head entry only when the ROB and the RS selected by the entry's op_type can both accept it.
- Clears all buffered entries on a pipeline flush.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict/exception flush; synchronous clear.
- dec_in  in  $bits(id_dis_stage_reg_t)  decoded instruction; dec_in.valid is the enqueue request.
- dec_ready  out  1  queue can accept this cycle.
- alu_rs_ready  in  1  ALU RS has a free slot.
- mul_rs_ready  in  1  MUL RS has a free slot.
- br_rs_ready  in  1  branch RS has a free slot.
- mem_rs_ready  in  1  memory RS has a free slot.
- rob_ready  in  1  ROB has a free entry.
- dis_out  out  $bits(id_dis_stage_reg_t)  head entry contents; valid field = queue non-empty.
- dis_alu_valid  out  1  head is dispatched to the ALU RS this cycle.
- dis_mul_valid  out  1  head is dispatched to the MUL RS this cycle.
- dis_br_valid  out  1  head is dispatched to the branch RS this cycle.
- dis_mem_valid  out  1  head is dispatched to the memory RS this cycle.
- dis_fire  out  1  head leaves the queue this cycle; the ROB allocates on it.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - head pointer, tail pointer and count cleared to 0; entry storage need not be cleared.
  - Outputs while in reset: dec_ready=1, dis_fire=0, all dis_*_valid=0, dis_out.valid=0, count=0.
- Enqueue: when dec_in.valid && dec_ready && !flush, the entry is written at tail and tail increments, wrapping DEPTH-1 to 0.
- dec_ready = (count != DEPTH). It is combinational from registered count only.
- No enqueue-when-full, even if a dequeue happens in the same cycle.
- No bypass: an entry enqueued in cycle N is visible at dis_out no earlier than cycle N+1. Minimum latency is 1 cycle.
- dis_out is driven from the head entry register every cycle. Its valid field is forced to (count != 0).
- Dispatch condition (combinational), evaluated only when count != 0 and flush is low:
  - op_type alu: fire = rob_ready && alu_rs_ready; dis_alu_valid = fire.
  - op_type mul: fire = rob_ready && mul_rs_ready; dis_mul_valid = fire.
  - op_type br: fire = rob_ready && br_rs_ready; dis_br_valid = fire.
  - op_type mem: fire = rob_ready && mem_rs_ready; dis_mem_valid = fire.
  - op_type none (illegal/unsupported opcode): fire = rob_ready. No RS valid is asserted; the ROB marks the entry done.
- At most one dis_*_valid is high in any cycle. dis_fire is the OR of the class valids plus the op_type-none case.
- On dis_fire, head increments with wrap-around.
- Ordering is strictly in order: a stalled head blocks younger entries, even if their RS is ready.
- Count update:
  - +1 on enqueue only; -1 on fire only.
  - Unchanged when both or neither occur.
- Boundary cases:
  - Empty: count=0, so no fire and all valids low; enqueue proceeds.
  - Full: count=DEPTH, so dec_ready=0; a fire in that cycle makes dec_ready=1 next cycle.
- Flush:
  - In the flush cycle, dis_fire and all dis_*_valid are forced 0 and enqueue is suppressed.
  - Next edge: head=tail=0, count=0.
  - Flush takes priority over every simultaneous event.
- rob_ready and RS readies are sampled combinationally each cycle; holding them low stalls indefinitely with no state change.

Optional Feature:
- Macro DISPATCH_QUEUE_PERF_EN.
- When defined, adds three 32-bit saturating counter outputs, cleared on reset only (not on flush):
  - perf_stall_rob: head present, !rob_ready.
  - perf_stall_rs: head present, rob_ready, target RS not ready.
  - perf_full: count==DEPTH.
- Counters saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; the remaining behaviour is unchanged.

Test Plan:
- Reset, then one ALU instruction (addi, op_type alu) with all readies=1: accepted at edge 0; dis_alu_valid=1 and dis_fire=1 in cycle 1; count goes 1 then 0.
- Fill with 8 entries while rob_ready=0: count=8 and dec_ready=0; the 9th instruction is held by decode. Raise rob_ready with all RS ready: one fire per cycle in enqueue order; dec_ready=1 the cycle after the first fire.
- Head mul with mul_rs_ready=0, next entry alu with alu_rs_ready=1: no fire, alu never valid. Raise mul_rs_ready: mul fires, then alu the next cycle.
- op_type none head with rob_ready=1: dis_fire=1, all four class valids=0, count decrements.
- 5 entries queued, flush with rob_ready=1 and a new enqueue the same cycle: no fire and no enqueue; count=0 next cycle; a later enqueue appears at dis_out one cycle after it is accepted.
- Drop rst_n mid-stream with count=3: count=0 and dis_fire=0 immediately, asynchronously. After release, normal enqueue from empty; with the macro defined, perf counters read 0.

Source files
------------

// File: rtl/dispatch_queue_ctrl.sv
// Purpose: in-order dispatch queue between decode and the RS/ROB; optional perf counters under `DISPATCH_QUEUE_PERF_EN`.
// Latency: an enqueued entry is visible at dis_out one cycle later (no bypass); head issues combinationally.
// Backpressure: dec_ready drops when full; head stalls until the ROB and the target RS are both ready.

package dispatch_queue_pkg;

    // Instruction class; any unlisted encoding is treated as "none" (illegal/unsupported)
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ALU  = 3'd1,
        OP_MUL  = 3'd2,
        OP_BR   = 3'd3,
        OP_MEM  = 3'd4
    } op_type_e;

    // Decode -> dispatch stage register; valid sits in the MSB
    typedef struct packed {
        logic        valid;
        op_type_e    op_type;
        logic [4:0]  rd;
        logic [31:0] pc;
    } id_dis_stage_reg_t;

    localparam int DIS_W = $bits(id_dis_stage_reg_t);

endpackage

module dispatch_queue_ctrl
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DIS_W-1:0] dec_in,
    output logic             dec_ready,
    input  logic             alu_rs_ready,
    input  logic             mul_rs_ready,
    input  logic             br_rs_ready,
    input  logic             mem_rs_ready,
    input  logic             rob_ready,
    output logic [DIS_W-1:0] dis_out,
    output logic             dis_alu_valid,
    output logic             dis_mul_valid,
    output logic             dis_br_valid,
    output logic             dis_mem_valid,
    output logic             dis_fire,
    output logic [CNT_W-1:0] count
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]      perf_stall_rob,
    output logic [31:0]      perf_stall_rs,
    output logic [31:0]      perf_full
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    id_dis_stage_reg_t mem [DEPTH];

    id_dis_stage_reg_t dec_s;
    id_dis_stage_reg_t head_s;
    id_dis_stage_reg_t out_s;

    logic not_empty;
    logic full;
    logic enq;
    logic fire_none;

    assign dec_s     = id_dis_stage_reg_t'(dec_in);
    assign head_s    = mem[head_ptr];
    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));

    // Registered-count-only ready: a same-cycle dequeue never frees a slot for enqueue
    assign dec_ready = !full;
    assign enq       = dec_s.valid && dec_ready && !flush;

    // Head entry is always presented; valid reflects occupancy, not the stored bit
    always_comb begin
        out_s       = head_s;
        out_s.valid = not_empty;
    end
    assign dis_out = out_s;

    // Issue decision for the head: ROB plus the class RS must be ready; flush blocks everything
    always_comb begin
        dis_alu_valid = 1'b0;
        dis_mul_valid = 1'b0;
        dis_br_valid  = 1'b0;
        dis_mem_valid = 1'b0;
        fire_none     = 1'b0;
        if (not_empty && !flush) begin
            case (head_s.op_type)
                OP_ALU:  dis_alu_valid = rob_ready && alu_rs_ready;
                OP_MUL:  dis_mul_valid = rob_ready && mul_rs_ready;
                OP_BR:   dis_br_valid  = rob_ready && br_rs_ready;
                OP_MEM:  dis_mem_valid = rob_ready && mem_rs_ready;
                default: fire_none     = rob_ready;
            endcase
        end
    end

    assign dis_fire = dis_alu_valid | dis_mul_valid | dis_br_valid | dis_mem_valid | fire_none;

    // Entry storage: written at tail on accepted enqueue, never cleared
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_ptr] <= dec_s;
        end
    end

    // Pointers and occupancy; flush wins over any simultaneous enqueue/fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (dis_fire) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(dis_fire);
        end
    end

`ifdef DISPATCH_QUEUE_PERF_EN
    logic target_rs_ready;

    // Readiness of the RS the head targets; class "none" needs no RS
    always_comb begin
        case (head_s.op_type)
            OP_ALU:  target_rs_ready = alu_rs_ready;
            OP_MUL:  target_rs_ready = mul_rs_ready;
            OP_BR:   target_rs_ready = br_rs_ready;
            OP_MEM:  target_rs_ready = mem_rs_ready;
            default: target_rs_ready = 1'b1;
        endcase
    end

    // Saturating stall/full event counters; survive flush, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_rob <= '0;
            perf_stall_rs  <= '0;
            perf_full      <= '0;
        end else begin
            if (not_empty && !rob_ready && (perf_stall_rob != 32'hFFFF_FFFF)) begin
                perf_stall_rob <= perf_stall_rob + 32'd1;
            end
            if (not_empty && rob_ready && !target_rs_ready && (perf_stall_rs != 32'hFFFF_FFFF)) begin
                perf_stall_rs <= perf_stall_rs + 32'd1;
            end
            if (full && (perf_full != 32'hFFFF_FFFF)) begin
                perf_full <= perf_full + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_queue_ctrl.sv
// Purpose: directed self-checking bench for dispatch_queue_ctrl.
// Latency: checks combinational outputs 2ns after each rising edge, state after the edge.
// Backpressure: exercises ROB/RS stalls, full queue, flush and async reset.

module tb_dispatch_queue_ctrl;
    import dispatch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic [DIS_W-1:0] dec_in = '0;
    logic             dec_ready;
    logic             alu_rs_ready = 1'b0;
    logic             mul_rs_ready = 1'b0;
    logic             br_rs_ready = 1'b0;
    logic             mem_rs_ready = 1'b0;
    logic             rob_ready = 1'b0;
    logic [DIS_W-1:0] dis_out;
    logic             dis_alu_valid;
    logic             dis_mul_valid;
    logic             dis_br_valid;
    logic             dis_mem_valid;
    logic             dis_fire;
    logic [CNT_W-1:0] count;
`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0]      perf_stall_rob;
    logic [31:0]      perf_stall_rs;
    logic [31:0]      perf_full;
`endif

    id_dis_stage_reg_t out_s;
    assign out_s = id_dis_stage_reg_t'(dis_out);

    int checks = 0;
    int errors = 0;

    dispatch_queue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .dec_in        (dec_in),
        .dec_ready     (dec_ready),
        .alu_rs_ready  (alu_rs_ready),
        .mul_rs_ready  (mul_rs_ready),
        .br_rs_ready   (br_rs_ready),
        .mem_rs_ready  (mem_rs_ready),
        .rob_ready     (rob_ready),
        .dis_out       (dis_out),
        .dis_alu_valid (dis_alu_valid),
        .dis_mul_valid (dis_mul_valid),
        .dis_br_valid  (dis_br_valid),
        .dis_mem_valid (dis_mem_valid),
        .dis_fire      (dis_fire),
        .count         (count)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .perf_stall_rob(perf_stall_rob),
        .perf_stall_rs (perf_stall_rs),
        .perf_full     (perf_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIS_W-1:0] mk(input op_type_e op, input logic [31:0] pc);
        id_dis_stage_reg_t s;
        s.valid   = 1'b1;
        s.op_type = op;
        s.rd      = pc[4:0];
        s.pc      = pc;
        return s;
    endfunction

    task automatic set_rdy(input logic rob, input logic alu, input logic mul, input logic br, input logic mm);
        rob_ready    = rob;
        alu_rs_ready = alu;
        mul_rs_ready = mul;
        br_rs_ready  = br;
        mem_rs_ready = mm;
    endtask

    function automatic logic [3:0] valids();
        return {dis_alu_valid, dis_mul_valid, dis_br_valid, dis_mem_valid};
    endfunction

    function automatic logic [3:0] onehot(input op_type_e op);
        case (op)
            OP_ALU:  return 4'b1000;
            OP_MUL:  return 4'b0100;
            OP_BR:   return 4'b0010;
            OP_MEM:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        op_type_e ops [4];
        ops[0] = OP_ALU; ops[1] = OP_MUL; ops[2] = OP_BR; ops[3] = OP_MEM;

        // ---- reset state ----
        #1 rst_n = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_dec_ready", 64'(dec_ready), 64'd1);
        check("rst_fire", 64'(dis_fire), 64'd0);
        check("rst_valids", 64'(valids()), 64'd0);
        check("rst_out_valid", 64'(out_s.valid), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // ---- single ALU instruction, all ready ----
        set_rdy(1, 1, 1, 1, 1);
        dec_in = mk(OP_ALU, 32'h100);
        #1;
        check("t1_empty_fire", 64'(dis_fire), 64'd0);
        check("t1_ready", 64'(dec_ready), 64'd1);
        tick();
        dec_in = '0;
        #1;
        check("t1_count1", 64'(count), 64'd1);
        check("t1_alu_valid", 64'(valids()), 64'b1000);
        check("t1_fire", 64'(dis_fire), 64'd1);
        check("t1_pc", 64'(out_s.pc), 64'h100);
        tick();
        check("t1_count0", 64'(count), 64'd0);

        // ---- fill to full with ROB stalled ----
        set_rdy(0, 1, 1, 1, 1);
        for (int i = 0; i < DEPTH; i++) begin
            dec_in = mk(ops[i % 4], 32'h200 + 32'(i));
            tick();
        end
        dec_in = mk(OP_ALU, 32'h900);
        #1;
        check("t2_full_count", 64'(count), 64'd8);
        check("t2_full_ready", 64'(dec_ready), 64'd0);
        check("t2_full_nofire", 64'(dis_fire), 64'd0);
        tick();
        check("t2_held_count", 64'(count), 64'd8);
        rob_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            logic [31:0] exp_pc;
            op_type_e    exp_op;
            exp_pc = (k < DEPTH) ? 32'h200 + 32'(k) : 32'h900;
            exp_op = (k < DEPTH) ? ops[k % 4] : OP_ALU;
            #1;
            check("t2_drain_fire", 64'(dis_fire), 64'd1);
            check("t2_drain_pc", 64'(out_s.pc), 64'(exp_pc));
            check("t2_drain_class", 64'(valids()), 64'(onehot(exp_op)));
            if (k == 0) check("t2_ready_fire0", 64'(dec_ready), 64'd0);
            if (k == 1) check("t2_ready_fire1", 64'(dec_ready), 64'd1);
            tick();
            if (k == 1) dec_in = '0;
        end
        check("t2_drained", 64'(count), 64'd0);

        // ---- in-order blocking: stalled MUL head blocks ready ALU ----
        set_rdy(1, 1, 0, 1, 1);
        dec_in = mk(OP_MUL, 32'h300);
        tick();
        dec_in = mk(OP_ALU, 32'h301);
        #1;
        check("t3_mul_stall", 64'(dis_fire), 64'd0);
        tick();
        dec_in = '0;
        #1;
        check("t3_count2", 64'(count), 64'd2);
        check("t3_no_valids", 64'(valids()), 64'd0);
        tick();
        check("t3_still2", 64'(count), 64'd2);
        check("t3_head_mul", 64'(out_s.pc), 64'h300);
        mul_rs_ready = 1'b1;
        #1;
        check("t3_mul_fire", 64'(valids()), 64'b0100);
        tick();
        #1;
        check("t3_alu_fire", 64'(valids()), 64'b1000);
        check("t3_alu_pc", 64'(out_s.pc), 64'h301);
        tick();
        check("t3_empty", 64'(count), 64'd0);

        // ---- op_type none retires through the ROB only ----
        set_rdy(1, 0, 0, 0, 0);
        dec_in = mk(OP_NONE, 32'h400);
        tick();
        dec_in = '0;
        #1;
        check("t4_fire", 64'(dis_fire), 64'd1);
        check("t4_valids", 64'(valids()), 64'd0);
        check("t4_count1", 64'(count), 64'd1);
        tick();
        check("t4_count0", 64'(count), 64'd0);

        // ---- flush with pending fire and enqueue ----
        set_rdy(0, 1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            dec_in = mk(OP_ALU, 32'h500 + 32'(i));
            tick();
        end
        check("t5_count5", 64'(count), 64'd5);
        rob_ready = 1'b1;
        flush = 1'b1;
        dec_in = mk(OP_ALU, 32'h599);
        #1;
        check("t5_flush_fire", 64'(dis_fire), 64'd0);
        check("t5_flush_valids", 64'(valids()), 64'd0);
        tick();
        flush = 1'b0;
        dec_in = '0;
        rob_ready = 1'b0;
        check("t5_count0", 64'(count), 64'd0);
        check("t5_out_invalid", 64'(out_s.valid), 64'd0);
        tick();
        dec_in = mk(OP_ALU, 32'h510);
        #1;
        check("t5_no_bypass", 64'(out_s.valid), 64'd0);
        tick();
        dec_in = '0;
        check("t5_visible", 64'(out_s.valid), 64'd1);
        check("t5_pc", 64'(out_s.pc), 64'h510);
        check("t5_count1", 64'(count), 64'd1);
        rob_ready = 1'b1;
        tick();
        check("t5_drained", 64'(count), 64'd0);

        // ---- asynchronous reset mid-stream ----
        rob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dec_in = mk(OP_ALU, 32'h600 + 32'(i));
            tick();
        end
        dec_in = '0;
        check("t6_count3", 64'(count), 64'd3);
        rob_ready = 1'b1;
        #1;
        check("t6_fire_before", 64'(dis_fire), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_fire", 64'(dis_fire), 64'd0);
        check("t6_async_ready", 64'(dec_ready), 64'd1);
        #3 rst_n = 1'b1;
        rob_ready = 1'b0;
`ifdef DISPATCH_QUEUE_PERF_EN
        #1;
        check("t6_perf_rob", 64'(perf_stall_rob), 64'd0);
        check("t6_perf_rs", 64'(perf_stall_rs), 64'd0);
        check("t6_perf_full", 64'(perf_full), 64'd0);
`endif
        tick();
        dec_in = mk(OP_BR, 32'h700);
        tick();
        dec_in = '0;
        check("t6_post_count", 64'(count), 64'd1);
        check("t6_post_pc", 64'(out_s.pc), 64'h700);
        br_rs_ready = 1'b1;
        rob_ready = 1'b1;
        #1;
        check("t6_post_br", 64'(valids()), 64'b0010);
        tick();
        check("t6_post_empty", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
